// File: rtl/rep_id_gen_if.sv
// rep_id_gen_if: request / ID-stream bundle for rep_id_gen.
//   start_valid/start_ready : range request handshake (lo_in, hi_in ride with it)
//   id_out_valid/id_out_ready : emitted ID handshake (id_out rides with it)
//   done    : one-cycle pulse when a range has been fully enumerated
//   sum_out : sum of all IDs handshaken for the last range
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready; the producer holds valid and its payload stable until
// that edge and never withdraws valid without a transfer (reset excepted).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

interface rep_id_gen_if;
   logic                          start_valid;
   logic                          start_ready;
   logic [`DATA_WIDTH-1:0]        lo_in;
   logic [`DATA_WIDTH-1:0]        hi_in;
   logic                          id_out_valid;
   logic                          id_out_ready;
   logic [`DATA_WIDTH-1:0]        id_out;
   logic                          done;
   logic [`LONG_DATA_WIDTH-1:0]   sum_out;

   // requester / ID consumer side
   modport master (
      output start_valid, lo_in, hi_in, id_out_ready,
      input  start_ready, id_out_valid, id_out, done, sum_out
   );

   // generator side
   modport slave (
      input  start_valid, lo_in, hi_in, id_out_ready,
      output start_ready, id_out_valid, id_out, done, sum_out
   );
endinterface

// File: rtl/rep_id_gen.sv
// rep_id_gen: streams, in ascending order, every integer in [lo, hi] whose
// decimal string is one block (no leading zero) repeated exactly REP_N times,
// and reports the running sum of the emitted values.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : rep_id_gen_if.slave (request, ID stream, done, sum_out)
//   dbg_state    : current FSM state encoding (IDLE=0 .. FIN=6)
// Every d-digit repeated number is x*base, base = sum_k 10^(k*d/REP_N) and
// x a (d/REP_N)-digit block, so each digit count d is one contiguous x range.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

module rep_id_gen #(
   parameter int REP_N    = 2,
   parameter int MAX_DIGS = 10
) (
   input  logic            clock,
   input  logic            reset,
   rep_id_gen_if.slave     bus,
   output logic [2:0]      dbg_state
);
   localparam int DW = `DATA_WIDTH;
   localparam int LW = `LONG_DATA_WIDTH;
   localparam logic [7:0] REP8 = 8'(REP_N);

   typedef enum logic [2:0] {IDLE, DIGS, BASE, SEEK, EMIT, NEXTD, FIN} state_t;
   state_t state;

   logic          start_ready_r, id_valid_r, done_r;
   logic [LW-1:0] lo_r, hi_r, base, term, p10b, x, ub, cur, sum;
   logic [7:0]    d, dmax, b, k;

   // 10^e, e bounded by MAX_DIGS so the loop has a constant trip count
   function automatic logic [LW-1:0] pow10(input logic [7:0] e);
      logic [LW-1:0] p;
      p = LW'(1);
      for (int i = 0; i <= MAX_DIGS; i++)
         if (8'(i) < e) p = p * LW'(10);
      return p;
   endfunction

   // decimal digit count, saturating at MAX_DIGS
   function automatic logic [7:0] digits(input logic [LW-1:0] v);
      logic [7:0] c;
      c = 8'd1;
      for (int i = 1; i < MAX_DIGS; i++)
         if (v >= pow10(8'(i))) c = 8'(i + 1);
      return c;
   endfunction

   logic [7:0]    lo_digs, hi_digs, d_chk, b_chk;
   logic          grp_ok;
   logic [LW-1:0] lb, ub_cap, hi_q, lo_q, ub_c, x_c;

   always_comb begin
      lo_digs = digits(lo_r);
      hi_digs = digits(hi_r);
      // DIGS tests the digit count of lo; NEXTD tests the following count
      d_chk   = (state == DIGS) ? lo_digs : d + 8'd1;
      grp_ok  = (d_chk % REP8) == 8'd0;
      b_chk   = d_chk / REP8;
      // block range for this digit group, clipped to [lo, hi]
      lb      = pow10(b - 8'd1);
      ub_cap  = p10b - LW'(1);
      hi_q    = hi_r / base;
      lo_q    = (lo_r + base - LW'(1)) / base;   // ceil(lo / base)
      ub_c    = (hi_q < ub_cap) ? hi_q : ub_cap;
      x_c     = (lo_q > lb) ? lo_q : lb;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         start_ready_r <= 1'b1;
         id_valid_r    <= 1'b0;
         done_r        <= 1'b0;
         lo_r          <= '0;
         hi_r          <= '0;
         base          <= '0;
         term          <= '0;
         p10b          <= '0;
         x             <= '0;
         ub            <= '0;
         cur           <= '0;
         sum           <= '0;
         d             <= '0;
         dmax          <= '0;
         b             <= '0;
         k             <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_valid && start_ready_r) begin
                  lo_r          <= (bus.lo_in == '0) ? LW'(1) : LW'(bus.lo_in);
                  hi_r          <= LW'(bus.hi_in);
                  sum           <= '0;
                  start_ready_r <= 1'b0;
                  state         <= DIGS;
               end
            end
            DIGS, NEXTD: begin
               d <= d_chk;
               if (state == DIGS) dmax <= hi_digs;
               if ((state == DIGS && hi_r < lo_r) ||
                   (state == NEXTD && d_chk > dmax)) begin
                  done_r <= 1'b1;
                  state  <= FIN;
               end else if (!grp_ok) begin
                  state <= NEXTD;
               end else begin
                  b     <= b_chk;
                  p10b  <= pow10(b_chk);
                  base  <= '0;
                  term  <= LW'(1);
                  k     <= '0;
                  state <= BASE;
               end
            end
            BASE: begin
               // one term 10^(k*b) per cycle, REP_N cycles in total
               base <= base + term;
               term <= term * p10b;
               k    <= k + 8'd1;
               if (k == REP8 - 8'd1) state <= SEEK;
            end
            SEEK: begin
               if (x_c > ub_c) begin
                  state <= NEXTD;
               end else begin
                  x          <= x_c;
                  ub         <= ub_c;
                  cur        <= x_c * base;
                  id_valid_r <= 1'b1;
                  state      <= EMIT;
               end
            end
            EMIT: begin
               if (bus.id_out_ready) begin
                  sum <= sum + cur;
                  x   <= x + LW'(1);
                  cur <= cur + base;
                  if (x == ub) begin
                     id_valid_r <= 1'b0;
                     state      <= NEXTD;
                  end
               end
            end
            FIN: begin
               done_r        <= 1'b0;
               start_ready_r <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.start_ready  = start_ready_r;
   assign bus.id_out_valid = id_valid_r;
   assign bus.id_out       = cur[DW-1:0];   // cur <= hi here, so no loss
   assign bus.done         = done_r;
   assign bus.sum_out      = sum;
   assign dbg_state        = state;
endmodule

// File: tb/tb_rep_id_gen.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

module tb_rep_id_gen;
   logic clock;
   logic reset;
   logic rdy;
   logic [2:0] dbg2, dbg3;

   rep_id_gen_if if2();
   rep_id_gen_if if3();

   rep_id_gen #(.REP_N(2), .MAX_DIGS(10)) u_rep2 (
      .clock(clock), .reset(reset), .bus(if2), .dbg_state(dbg2));
   rep_id_gen #(.REP_N(3), .MAX_DIGS(10)) u_rep3 (
      .clock(clock), .reset(reset), .bus(if3), .dbg_state(dbg3));

   assign if2.id_out_ready = rdy;
   assign if3.id_out_ready = rdy;

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          r3;      // 1: REP_N=3 instance, 0: REP_N=2 instance
      logic [31:0] lo;
      logic [31:0] hi;
      logic [31:0] first;   // expected IDs: first + i*step, i < n
      logic [31:0] step;
      int          n;
      logic [63:0] sum;
      int          maxc;    // cycle budget from start to done
   } vec_t;
   vec_t vecs[7];

   // ---------------- driver tasks ----------------
   task automatic sample(input bit r3, output logic v, output logic [31:0] id,
                         output logic dn, output logic [63:0] s, output logic sr);
      if (r3) begin
         v = if3.id_out_valid; id = if3.id_out; dn = if3.done;
         s = if3.sum_out; sr = if3.start_ready;
      end else begin
         v = if2.id_out_valid; id = if2.id_out; dn = if2.done;
         s = if2.sum_out; sr = if2.start_ready;
      end
   endtask

   task automatic start_req(input bit r3, input logic [31:0] lo, input logic [31:0] hi);
      @(negedge clock);
      if (r3) begin
         if3.lo_in = lo; if3.hi_in = hi; if3.start_valid = 1'b1;
      end else begin
         if2.lo_in = lo; if2.hi_in = hi; if2.start_valid = 1'b1;
      end
      @(negedge clock);
      if2.start_valid = 1'b0;
      if3.start_valid = 1'b0;
   endtask

   // consume IDs against exp_q until done, then check sum and the done pulse
   task automatic collect(input bit r3, input int maxc, input logic [63:0] exp_sum,
                          input string tag);
      logic v, dn, sr;
      logic [31:0] id;
      logic [63:0] s;
      int cyc = 0;
      bit seen_done = 0;
      while (cyc < maxc && !seen_done) begin
         @(negedge clock);
         cyc++;
         sample(r3, v, id, dn, s, sr);
         if (v && rdy) begin
            if (exp_q.size() == 0) check({tag, " extra_id"}, 64'(id), 64'hFFFF_FFFF_FFFF_FFFF);
            else check({tag, " id"}, 64'(id), 64'(exp_q.pop_front()));
         end
         if (dn) seen_done = 1;
      end
      check({tag, " done_seen"}, 64'(seen_done), 64'd1);
      check({tag, " ids_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, " sum"}, s, exp_sum);
      exp_q.delete();
      @(negedge clock);
      sample(r3, v, id, dn, s, sr);
      check({tag, " done_pulse_end"}, 64'(dn), 64'd0);
      check({tag, " start_ready_back"}, 64'(sr), 64'd1);
      check({tag, " sum_hold"}, s, exp_sum);
   endtask

   task automatic run_vec(input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      exp_q.delete();
      for (int i = 0; i < vecs[idx].n; i++)
         exp_q.push_back(vecs[idx].first + 32'(i) * vecs[idx].step);
      start_req(vecs[idx].r3, vecs[idx].lo, vecs[idx].hi);
      collect(vecs[idx].r3, vecs[idx].maxc, vecs[idx].sum, tag);
   endtask

   // ---------------- test ----------------
   initial begin
      logic v, dn, sr;
      logic [31:0] id;
      logic [63:0] s;
      int cnt, cyc;
      bit bad;

      vecs[0] = '{1'b0, 32'd11,         32'd22,         32'd11,         32'd11,  2, 64'd33,         200};
      vecs[1] = '{1'b0, 32'd95,         32'd115,        32'd99,         32'd0,   1, 64'd99,         200};
      vecs[2] = '{1'b0, 32'd998,        32'd1012,       32'd1010,       32'd0,   1, 64'd1010,       200};
      vecs[3] = '{1'b0, 32'd50,         32'd40,         32'd0,          32'd0,   0, 64'd0,          3};
      vecs[4] = '{1'b0, 32'd0,          32'd10,         32'd0,          32'd0,   0, 64'd0,          200};
      vecs[5] = '{1'b1, 32'd1,          32'd1000,       32'd111,        32'd111, 9, 64'd4995,       200};
      vecs[6] = '{1'b0, 32'd1188511880, 32'd1188511890, 32'd1188511885, 32'd0,   1, 64'd1188511885, 300};

      rdy = 1'b1;
      if2.start_valid = 1'b0; if2.lo_in = '0; if2.hi_in = '0;
      if3.start_valid = 1'b0; if3.lo_in = '0; if3.hi_in = '0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      for (int r = 0; r < 2; r++) begin
         sample(r == 1, v, id, dn, s, sr);
         check($sformatf("reset%0d start_ready", r), 64'(sr), 64'd1);
         check($sformatf("reset%0d id_out_valid", r), 64'(v), 64'd0);
         check($sformatf("reset%0d id_out", r), 64'(id), 64'd0);
         check($sformatf("reset%0d done", r), 64'(dn), 64'd0);
         check($sformatf("reset%0d sum_out", r), s, 64'd0);
      end
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(i);

      // backpressure: hold ready low for 3 cycles once 11 is offered
      rdy = 1'b0;
      start_req(1'b0, 32'd11, 32'd22);
      cyc = 0;
      v = 1'b0;
      while (!v && cyc < 50) begin
         @(negedge clock);
         cyc++;
         sample(1'b0, v, id, dn, s, sr);
      end
      check("bp first_valid", 64'(v), 64'd1);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin
            @(negedge clock);
            sample(1'b0, v, id, dn, s, sr);
         end
         check($sformatf("bp%0d valid", c), 64'(v), 64'd1);
         check($sformatf("bp%0d id", c), 64'(id), 64'd11);
         check($sformatf("bp%0d sum", c), s, 64'd0);
      end
      @(negedge clock);
      sample(1'b0, v, id, dn, s, sr);
      check("bp after_stall id", 64'(id), 64'd11);
      rdy = 1'b1;
      exp_q.delete();
      exp_q.push_back(32'd22);
      collect(1'b0, 200, 64'd33, "bp");

      // reset in the middle of the REP_N=3 stream after 4 IDs
      start_req(1'b1, 32'd1, 32'd1000);
      cnt = 0;
      cyc = 0;
      while (cnt < 4 && cyc < 200) begin
         @(negedge clock);
         cyc++;
         sample(1'b1, v, id, dn, s, sr);
         if (v && rdy) begin
            check($sformatf("rst_run id%0d", cnt), 64'(id), 64'(111 * (cnt + 1)));
            cnt++;
         end
      end
      check("rst_run four_ids", 64'(cnt), 64'd4);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      sample(1'b1, v, id, dn, s, sr);
      check("rst_mid valid", 64'(v), 64'd0);
      check("rst_mid sum", s, 64'd0);
      check("rst_mid start_ready", 64'(sr), 64'd1);
      check("rst_mid done", 64'(dn), 64'd0);
      reset = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clock);
         sample(1'b1, v, id, dn, s, sr);
         if (v || dn) bad = 1;
      end
      check("rst_quiet no_emit_no_done", 64'(bad), 64'd0);
      run_vec(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
